// File: rtl/fp_div_seq.sv
`default_nettype none
// ==== fp_div_seq : sequential radix-2 restoring FP32 divider, hidden-1, truncating ==== rev 1.0 ====
module fp_div_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [4:0] C_LAST_ITER = 5'd23;

  state_t state, state_nxt;

  logic [N-1:0] r_a, r_b;
  logic [24:0]  r_rem;
  logic [23:0]  r_q;
  logic [4:0]   r_cnt;
  logic         r_sign;
  logic [7:0]   r_exp;
  logic [N-1:0] r_result;

  logic [23:0]  w_am, w_bm;
  logic         w_a_zero, w_b_zero, w_special, w_am_lt_bm;
  logic [N-1:0] w_special_res;
  logic [7:0]   w_exp;
  logic         w_ge;
  logic [24:0]  w_rem_sub, w_rem_next;
  logic [23:0]  w_q_next;

  assign w_am       = {1'b1, r_a[22:0]};
  assign w_bm       = {1'b1, r_b[22:0]};
  assign w_a_zero   = (r_a == '0);
  assign w_b_zero   = (r_b == '0);
  assign w_special  = w_a_zero | w_b_zero;
  assign w_am_lt_bm = (w_am < w_bm);

  // Priority: 0/0 -> quiet NaN, 0/x -> +0, x/0 -> signed infinity.
  always_comb begin
    w_special_res = '0;
    if (w_a_zero && w_b_zero)
      w_special_res = 32'h7FC0_0000;
    else if (w_a_zero)
      w_special_res = 32'h0000_0000;
    else
      w_special_res = {r_a[31] ^ r_b[31], 8'hFF, 23'd0};
  end

  // Pre-normalising the dividend guarantees the first quotient bit is 1.
  assign w_exp = r_a[30:23] - r_b[30:23] + (w_am_lt_bm ? 8'd126 : 8'd127);

  assign w_ge       = (r_rem >= {1'b0, w_bm});
  assign w_rem_sub  = r_rem - {1'b0, w_bm};
  assign w_rem_next = w_ge ? {w_rem_sub[23:0], 1'b0} : {r_rem[23:0], 1'b0};
  assign w_q_next   = {r_q[22:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid)             state_nxt = PREP;
      PREP: state_nxt = w_special ? DONE : CALC;
      CALC: if (r_cnt == C_LAST_ITER) state_nxt = DONE;
      DONE: if (out_ready)            state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            r_a <= a;
            r_b <= b;
          end
        end
        PREP: begin
          if (w_special) begin
            r_result <= w_special_res;
          end else begin
            r_sign <= r_a[31] ^ r_b[31];
            r_exp  <= w_exp;
            r_rem  <= w_am_lt_bm ? {w_am, 1'b0} : {1'b0, w_am};
            r_q    <= '0;
            r_cnt  <= '0;
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == C_LAST_ITER)
            r_result <= {r_sign, r_exp, w_q_next[22:0]};
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_fp_div_seq.sv
`default_nettype none
// ==== tb_fp_div_seq : self-checking bench for fp_div_seq ==== rev 1.0 ====
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fp_div_seq #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", name, got, want);
    end
  endtask

  // Reference: quotient of hidden-1 mantissas by integer division, exponent mod 256.
  function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    logic [63:0] xm, ym, q;
    logic [7:0]  e;
    s = x[31] ^ y[31];
    if (x == 0 && y == 0) return 32'h7FC0_0000;
    if (x == 0)           return 32'h0000_0000;
    if (y == 0)           return {s, 8'hFF, 23'd0};
    xm = {40'd1, x[22:0]};
    ym = {40'd1, y[22:0]};
    if (xm < ym) begin
      q = (xm << 24) / ym;
      e = x[30:23] - y[30:23] + 8'd126;
    end else begin
      q = (xm << 23) / ym;
      e = x[30:23] - y[30:23] + 8'd127;
    end
    return {s, e, q[22:0]};
  endfunction

  // Entered #1 after a posedge with the DUT idle; returns edges from accept to out_valid.
  task automatic start_op(input logic [31:0] av, input logic [31:0] bv,
                          output int lat, output bit ready_seen);
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    ready_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);
    check("drain_in_ready",  {31'd0, in_ready},  32'd1);
  endtask

  vec_t        vecs[$];
  logic [31:0] pa[8], pb[8];
  logic [31:0] held;
  int          lat, guard, n_out, idx_in, last_acc;
  bit          rdy, acc;

  initial begin
    vecs.push_back('{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 25});
    vecs.push_back('{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 25});
    vecs.push_back('{32'hBFC0_0000, 32'h3F00_0000, 32'hC040_0000, 25});
    vecs.push_back('{32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 1});
    vecs.push_back('{32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1});
    vecs.push_back('{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 25});
    vecs.push_back('{32'h3F80_0000, 32'h8000_0000, 32'hFF00_0000, 25});
    vecs.push_back('{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1});

    #12;
    check("reset_in_ready",  {31'd0, in_ready},  32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result",    result,             32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, lat, rdy);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_in_ready_low", i), {31'd0, rdy}, 32'd0);
      check($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
      if (lat < 40) consume();
    end

    // Back-pressure: result and handshake frozen while the consumer stalls.
    start_op(32'h40C0_0000, 32'h4000_0000, lat, rdy);
    held = result;
    for (int c = 0; c < 10; c++) begin
      a = $urandom; b = $urandom; in_valid = c[0];
      @(posedge clk); #1;
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready",  {31'd0, in_ready},  32'd0);
      check("bp_result",    result,             32'h4040_0000);
    end
    in_valid = 1'b0;
    check("bp_result_held", result, held);
    consume();

    // Back-to-back random normal operands with both handshakes held high.
    for (int i = 0; i < 8; i++) begin
      pa[i] = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
      pb[i] = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
    end
    a = pa[0]; b = pb[0]; in_valid = 1'b1; out_ready = 1'b1;
    n_out = 0; idx_in = 0; guard = 0; last_acc = -1;
    while (n_out < 8 && guard < 400) begin
      @(negedge clk);
      acc = in_ready && in_valid;
      if (out_valid) begin
        check($sformatf("b2b%0d_result", n_out), result, ref_div(pa[n_out], pb[n_out]));
        n_out++;
      end
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        if (last_acc >= 0) check("b2b_accept_spacing", guard - last_acc, 27);
        last_acc = guard;
        idx_in++;
        if (idx_in < 8) begin a = pa[idx_in]; b = pb[idx_in]; end
        else in_valid = 1'b0;
      end
    end
    check("b2b_all_done", n_out, 8);
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of CALC.
    a = 32'h40C0_0000; b = 32'h4000_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_mid_result",    result,             32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    start_op(32'h4120_0000, 32'h40A0_0000, lat, rdy);
    check("post_rst_latency", lat, 25);
    check("post_rst_result", result, 32'h4000_0000);
    if (lat < 40) consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
